// File: rtl/nn_stream_pkg.sv
// Shared types and constants for the ANN stream controller family.
// Holds the controller state encoding and the address-width helper.
package nn_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_IN,
    START,
    WAIT,
    READ,
    DRAIN,
    FLUSH
  } state_e;

  localparam int DEF_DATA_W    = 128;
  localparam int DEF_WB_WORDS  = 7;
  localparam int DEF_IN_WORDS  = 4;
  localparam int DEF_OUT_WORDS = 2;
  localparam int DEF_CNT_W     = 16;

  // A depth-1 memory still needs a 1-bit address port.
  function automatic int clog2_min1(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry output buffer: push lands one cycle after the BRAM read, head is presented on valid.
// Head data/last stay stable while the consumer stalls; caller must not push when full without a pop.
module axis_skid2 #(
  parameter int DATA_W = 128
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              push_last_i,
  output logic              m_vld_o,
  output logic [DATA_W-1:0] m_dat_o,
  output logic              m_last_o,
  input  logic              m_rdy_i,
  output logic [1:0]        occ_o
);

  logic [DATA_W-1:0] dat_q [2];
  logic [1:0]        last_q;
  logic              wr_q;
  logic              rd_q;
  logic [1:0]        occ_q;
  logic              pop;

  assign pop      = (occ_q != 2'd0) && m_rdy_i;
  assign m_vld_o  = (occ_q != 2'd0);
  assign m_dat_o  = dat_q[rd_q];
  assign m_last_o = last_q[rd_q];
  assign occ_o    = occ_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      occ_q  <= 2'd0;
      last_q <= 2'b00;
    end else begin
      if (push_i) begin
        dat_q[wr_q]  <= push_dat_i;
        last_q[wr_q] <= push_last_i;
        wr_q         <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/axis_nn_stream_ctrl.sv
// AXI-Stream front-end for the ANN core: loads weight/input BRAMs, starts the core, streams results.
// Input 1 word/cycle, START 1 cycle after the last beat; results stall without loss on m_axis_tready low.
module axis_nn_stream_ctrl
  import nn_stream_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int WB_WORDS  = DEF_WB_WORDS,
  parameter int IN_WORDS  = DEF_IN_WORDS,
  parameter int OUT_WORDS = DEF_OUT_WORDS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic                                cfg_keep_weights,
  output logic                                s_axis_tready,
  input  logic [DATA_W-1:0]                   s_axis_tdata,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  input  logic                                m_axis_tready,
  output logic [DATA_W-1:0]                   m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  output logic                                nn_start,
  input  logic                                nn_ready,
  output logic                                wb_ena,
  output logic [DATA_W/8-1:0]                 wb_wea,
  output logic [clog2_min1(WB_WORDS)-1:0]     wb_addra,
  output logic [DATA_W-1:0]                   wb_dina,
  output logic                                k_ena,
  output logic [DATA_W/8-1:0]                 k_wea,
  output logic [clog2_min1(IN_WORDS)-1:0]     k_addra,
  output logic [DATA_W-1:0]                   k_dina,
  output logic                                a_enb,
  output logic [clog2_min1(OUT_WORDS)-1:0]    a_addrb,
  input  logic [DATA_W-1:0]                   a_doutb,
  output logic                                weights_valid,
  output logic [CNT_W-1:0]                    stat_pkts,
  output logic [CNT_W-1:0]                    stat_errs
);

  localparam int WB_AW  = clog2_min1(WB_WORDS);
  localparam int IN_AW  = clog2_min1(IN_WORDS);
  localparam int OUT_AW = clog2_min1(OUT_WORDS);
  localparam int MAX_WORDS = (WB_WORDS > IN_WORDS)
                           ? ((WB_WORDS > OUT_WORDS) ? WB_WORDS : OUT_WORDS)
                           : ((IN_WORDS > OUT_WORDS) ? IN_WORDS : OUT_WORDS);
  localparam int CW = clog2_min1(MAX_WORDS);
  localparam int BE_W = DATA_W / 8;
  localparam logic [CW-1:0] WB_LAST  = CW'(WB_WORDS - 1);
  localparam logic [CW-1:0] IN_LAST  = CW'(IN_WORDS - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(OUT_WORDS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              tready_q;
  logic              has_w_q;
  logic              wv_q;
  logic              start_q;
  logic              wb_ena_q;
  logic [WB_AW-1:0]  wb_addr_q;
  logic [DATA_W-1:0] wb_din_q;
  logic              k_ena_q;
  logic [IN_AW-1:0]  k_addr_q;
  logic [DATA_W-1:0] k_din_q;
  logic              rd_vld_q;
  logic              rd_last_q;
  logic [CNT_W-1:0]  pkts_q;
  logic [CNT_W-1:0]  errs_q;

  logic              beat;
  logic              pop;
  logic              issue;
  logic [1:0]        occ;

  assign beat = s_axis_tvalid && tready_q;
  assign pop  = m_axis_tvalid && m_axis_tready;
  // A pop in this cycle frees a slot before the issued word can land, so a steady
  // tready stream never bubbles while at most two words are ever owed to the buffer.
  assign issue = (state_q == READ) && ((int'(occ) + int'(rd_vld_q) - int'(pop)) < 2);

  assign s_axis_tready = tready_q;
  assign nn_start      = start_q;
  assign wb_ena        = wb_ena_q;
  assign wb_wea        = {BE_W{wb_ena_q}};
  assign wb_addra      = wb_addr_q;
  assign wb_dina       = wb_din_q;
  assign k_ena         = k_ena_q;
  assign k_wea         = {BE_W{k_ena_q}};
  assign k_addra       = k_addr_q;
  assign k_dina        = k_din_q;
  assign a_enb         = issue;
  assign a_addrb       = cnt_q[OUT_AW-1:0];
  assign weights_valid = wv_q;
  assign stat_pkts     = pkts_q;
  assign stat_errs     = errs_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tready_q  <= 1'b0;
      has_w_q   <= 1'b0;
      wv_q      <= 1'b0;
      start_q   <= 1'b0;
      wb_ena_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_din_q  <= '0;
      k_ena_q   <= 1'b0;
      k_addr_q  <= '0;
      k_din_q   <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      pkts_q    <= '0;
      errs_q    <= '0;
    end else begin
      wb_ena_q  <= 1'b0;
      k_ena_q   <= 1'b0;
      start_q   <= 1'b0;
      rd_vld_q  <= issue;
      rd_last_q <= issue && (cnt_q == OUT_LAST);
      case (state_q)
        IDLE: begin
          if (s_axis_tvalid) begin
            tready_q <= 1'b1;
            cnt_q    <= '0;
            if (cfg_keep_weights && wv_q) begin
              has_w_q <= 1'b0;
              state_q <= LOAD_IN;
            end else begin
              has_w_q <= 1'b1;
              state_q <= LOAD_W;
            end
          end
        end
        LOAD_W: begin
          if (beat) begin
            if (s_axis_tlast) begin
              errs_q   <= sat_inc(errs_q);
              wv_q     <= 1'b0;
              tready_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              wb_ena_q  <= 1'b1;
              wb_addr_q <= cnt_q[WB_AW-1:0];
              wb_din_q  <= s_axis_tdata;
              if (cnt_q == WB_LAST) begin
                cnt_q   <= '0;
                state_q <= LOAD_IN;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
        end
        LOAD_IN: begin
          if (beat) begin
            if (s_axis_tlast && (cnt_q != IN_LAST)) begin
              errs_q   <= sat_inc(errs_q);
              tready_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              k_ena_q  <= 1'b1;
              k_addr_q <= cnt_q[IN_AW-1:0];
              k_din_q  <= s_axis_tdata;
              if (cnt_q == IN_LAST) begin
                cnt_q <= '0;
                if (s_axis_tlast) begin
                  tready_q <= 1'b0;
                  start_q  <= 1'b1;
                  state_q  <= START;
                end else begin
                  errs_q  <= sat_inc(errs_q);
                  wv_q    <= 1'b0;
                  state_q <= FLUSH;
                end
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
        end
        START: begin
          if (has_w_q) begin
            wv_q <= 1'b1;
          end
          state_q <= WAIT;
        end
        WAIT: begin
          if (nn_ready) begin
            state_q <= READ;
          end
        end
        READ: begin
          if (issue) begin
            if (cnt_q == OUT_LAST) begin
              cnt_q   <= '0;
              state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (pop && m_axis_tlast) begin
            pkts_q  <= pkts_q + CNT_W'(1);
            state_q <= IDLE;
          end
        end
        FLUSH: begin
          if (beat && s_axis_tlast) begin
            tready_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_skid2 #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .push_i      (rd_vld_q),
    .push_dat_i  (a_doutb),
    .push_last_i (rd_last_q),
    .m_vld_o     (m_axis_tvalid),
    .m_dat_o     (m_axis_tdata),
    .m_last_o    (m_axis_tlast),
    .m_rdy_i     (m_axis_tready),
    .occ_o       (occ)
  );

endmodule
